gate_tt_checker: RTL

Sequencing controller that sweeps every input combination through an external 2-input-class gate under test, holds each vector for a programmable settle time, samples the gate output, and checks the captured truth table against an expected one. It replaces hand-written stimulus sequences for the basic-gate modules (nand_gate and its siblings) with a reusable, synthesizable self-check. It sits between a test or config master (start/expected) and one gate instance (gate_in/gate_y).

---
 rtl/gate_tt_pkg.sv | 24 ++
 rtl/gate_tt_cmp.sv | 29 ++
 rtl/gate_tt_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gate_tt_pkg;

   // Sweep controller states.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StApply  = 2'd1,
      StFinish = 2'd2
   } tt_state_e;

   // Reference truth tables for 2-input gates; bit i is the output for input vector i.
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   // Width of the settle counter, which must be able to hold SETTLE_CYC.
   function automatic int unsigned tt_cnt_width(input int unsigned settle_cyc);
      return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
   endfunction

endpackage

// File: rtl/gate_tt_cmp.sv
// Combinational truth-table comparator: equality flag plus lowest mismatching vector index.
module gate_tt_cmp
   import gate_tt_pkg::*;
#(
   parameter int unsigned N_IN = 2
) (
   input  logic [(1 << N_IN)-1:0] captured_i,
   input  logic [(1 << N_IN)-1:0] expected_i,
   output logic                   equal_o,
   output logic [N_IN-1:0]        mis_idx_o
);

   localparam int NV = 1 << N_IN;

   logic [NV-1:0] diff;

   // Priority encode the mismatch vector; scanning downwards leaves the lowest index last.
   always_comb begin
      diff      = captured_i ^ expected_i;
      equal_o   = (diff == '0);
      mis_idx_o = '0;
      for (int i = NV - 1; i >= 0; i--) begin
         if (diff[i]) begin
            mis_idx_o = i[N_IN-1:0];
         end
      end
   end

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps every input vector through an external gate, samples its output after a settle
// time and compares the captured truth table with a latched expectation.
module gate_tt_checker
   import gate_tt_pkg::*;
#(
   parameter int unsigned N_IN       = 2,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [(1 << N_IN)-1:0] expected_i,
   output logic [N_IN-1:0]        gate_in_o,
   input  logic                   gate_y_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic [(1 << N_IN)-1:0] captured_o,
   output logic [N_IN-1:0]        fail_idx_o
);

   localparam int unsigned NV   = 1 << N_IN;
   localparam int unsigned IdxW = N_IN + 1;
   localparam int unsigned CntW = tt_cnt_width(SETTLE_CYC);

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [CntW-1:0] cnt_t;

   localparam idx_t IdxLast   = idx_t'(NV - 1);
   localparam cnt_t CntSample = cnt_t'(SETTLE_CYC - 1);

   tt_state_e       state_q, state_d;
   logic [NV-1:0]   exp_q, exp_d;
   logic [NV-1:0]   captured_q, captured_d;
   logic            pass_q, pass_d;
   logic [N_IN-1:0] fail_idx_q, fail_idx_d;
   idx_t            idx_q, idx_d;
   cnt_t            cnt_q, cnt_d;

   logic            start_acc;
   logic            sample;
   logic            last_sample;
   logic            cmp_equal;
   logic [N_IN-1:0] cmp_idx;

   assign start_acc   = (state_q == StIdle) && start_i;
   assign sample      = (state_q == StApply) && (cnt_q == CntSample);
   assign last_sample = sample && (idx_q == IdxLast);

   // The comparator looks at the next captured value so the verdict is already registered
   // when done is high, rather than one cycle later.
   gate_tt_cmp #(
      .N_IN (N_IN)
   ) u_cmp (
      .captured_i (captured_d),
      .expected_i (exp_q),
      .equal_o    (cmp_equal),
      .mis_idx_o  (cmp_idx)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start is only honoured in idle; finish always lasts one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StApply;
            end
         end
         StApply: begin
            if (last_sample) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      busy_o    = 1'b0;
      done_o    = 1'b0;
      gate_in_o = '0;
      unique case (state_q)
         StIdle: begin
            busy_o = 1'b0;
         end
         StApply: begin
            busy_o    = 1'b1;
            gate_in_o = idx_q[N_IN-1:0];
         end
         StFinish: begin
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   // Datapath next-state: latch the job on start, step the settle counter and vector index,
   // capture gate_y at the end of each settle window and record the verdict on the last one.
   always_comb begin
      exp_d      = exp_q;
      captured_d = captured_q;
      pass_d     = pass_q;
      fail_idx_d = fail_idx_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;

      if (start_acc) begin
         exp_d      = expected_i;
         captured_d = '0;
         pass_d     = 1'b0;
         fail_idx_d = '0;
         idx_d      = '0;
         cnt_d      = '0;
      end

      if (state_q == StApply) begin
         if (sample) begin
            // gate_y is taken as-is so X/Z on the gate is visible in captured.
            captured_d[idx_q[N_IN-1:0]] = gate_y_i;
            cnt_d                       = '0;
            if (!last_sample) begin
               idx_d = idx_q + idx_t'(1);
            end
         end else begin
            cnt_d = cnt_q + cnt_t'(1);
         end
      end

      if (last_sample) begin
         pass_d     = cmp_equal;
         fail_idx_d = cmp_equal ? '0 : cmp_idx;
      end
   end

   // Datapath registers; reset clears every result and the latched expectation.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         exp_q      <= '0;
         captured_q <= '0;
         pass_q     <= 1'b0;
         fail_idx_q <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
      end else begin
         exp_q      <= exp_d;
         captured_q <= captured_d;
         pass_q     <= pass_d;
         fail_idx_q <= fail_idx_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pass_o     = pass_q;
   assign captured_o = captured_q;
   assign fail_idx_o = fail_idx_q;

endmodule
